// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// pointer/count width helpers and the read-mode selector constants.
package fifo_pkg;

  // Read-port behaviour selector used for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;  // registered read, one-cycle latency
  localparam int FIFO_MODE_FWFT = 1;  // head word continuously presented on dout

  // Address width needed to index `depth` entries (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the value DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage array: one synchronous write port and an
// asynchronous (combinational) read port. Contents are never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry on an accepted write.
  // NOTE: the array has no reset on purpose; occupancy tracking in the
  // controller guarantees stale words are never presented as valid, and a
  // reset here would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fifo_ram

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointer/occupancy control, status flags,
// sticky error flags and a read port that is either registered (standard)
// or first-word-fall-through, selected by the FWFT parameter.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ram_we;
  logic [WIDTH-1:0] w_ram_rdata;

  // rst and clear have identical effect on everything except storage.
  assign w_flush  = rst | clear;

  // Every status flag is a decode of the registered occupancy.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_FULL);

  // No bypass: a read is only accepted when a word is already stored, and
  // a write into a full FIFO is accepted only if a read frees a slot.
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);
  assign w_ram_we = w_wr_acc & ~w_flush;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  // Pointer, occupancy and sticky error flag update.
  // NOTE: state is assigned with non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results order-dependent.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
    end
  end

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is always on the bus; it is valid whenever anything is stored.
    assign dout       = w_ram_rdata;
    assign dout_valid = ~w_empty;
  end else begin : g_std
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    // Registered read: capture the head word on an accepted read.
    always_ff @(posedge clk) begin
      if (w_flush) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end else if (w_rd_acc) begin
        r_dout       <= w_ram_rdata;
        r_dout_valid <= 1'b1;
      end else begin
        r_dout_valid <= 1'b0;
      end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
  end

endmodule : fifo_sync_param

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: one standard-mode and one FWFT-mode instance
// driven by the same stimulus, checked against a queue-based model.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         clear = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din   = '0;

  logic [W-1:0] s_dout, f_dout;
  logic         s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic         f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0]   s_count, f_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: stored words in order, sticky flags, std read port.
  logic [W-1:0] q[$];
  logic         m_ovf, m_udf, m_dv;
  logic [W-1:0] m_dout;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(FIFO_MODE_STD)
  ) u_std (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(FIFO_MODE_FWFT)
  ) u_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // Behavioural model of one clock edge, from the FIFO's acceptance rules.
  function automatic void model_update(input logic r, input logic c, input logic w,
                                       input logic [W-1:0] d, input logic rd);
    int  n;
    bit  ra, wa;
    if (r || c) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = '0;
      return;
    end
    n  = q.size();
    ra = rd && (n > 0);
    wa = w && ((n < D) || ra);
    m_dv = ra;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    if (w && !wa)  m_ovf = 1'b1;
    if (rd && !ra) m_udf = 1'b1;
  endfunction

  // One clock of stimulus; outputs are stable and sampled 1 time unit later.
  task automatic drive(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; clear = c;
    @(posedge clk);
    model_update(rst, c, w, d, r);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Scenario 1: reset with a write request held high must leave the FIFO empty.
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", s_count); end
    checks++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100)
      begin errors++; $display("FAIL reset_flags got={e,ae,f,af}=%b exp=1100", {s_empty, s_ae, s_full, s_af}); end
    checks++; if ({s_dv, s_ovf, s_udf} !== 3'b000)
      begin errors++; $display("FAIL reset_dv_err got={dv,ovf,udf}=%b exp=000", {s_dv, s_ovf, s_udf}); end
    checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", s_dout); end
    checks++; if ({f_dv, f_empty, f_count} !== {1'b0, 1'b1, 4'd0})
      begin errors++; $display("FAIL reset_fwft got dv=%b empty=%b count=%0d exp dv=0 empty=1 count=0", f_dv, f_empty, f_count); end
  endtask

  // Scenario 2: fill to full, overfill, drain in order, then underflow.
  task automatic test_fill_overfill();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      checks++; if (s_count !== 4'(i)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, s_count, i); end
      checks++; if (s_af !== (i >= AF)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, s_af, (i >= AF)); end
      checks++; if (s_full !== (i == 8)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, s_full, (i == 8)); end
    end
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    checks++; if ({s_ovf, s_count} !== {1'b1, 4'd8})
      begin errors++; $display("FAIL overfill got ovf=%b count=%0d exp ovf=1 count=8", s_ovf, s_count); end
    for (int k = 1; k <= 8; k++) begin
      checks++; if ({f_dv, f_dout} !== {1'b1, W'(k)})
        begin errors++; $display("FAIL fwft_head k=%0d got dv=%b dout=%h exp dv=1 dout=%h", k, f_dv, f_dout, k); end
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if ({s_dv, s_dout} !== {1'b1, W'(k)})
        begin errors++; $display("FAIL drain_dout k=%0d got dv=%b dout=%h exp dv=1 dout=%h", k, s_dv, s_dout, k); end
    end
    checks++; if ({s_empty, s_udf} !== 2'b10)
      begin errors++; $display("FAIL drain_end got empty=%b udf=%b exp empty=1 udf=0", s_empty, s_udf); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({s_udf, s_dv, s_ovf, s_count} !== {1'b1, 1'b0, 1'b1, 4'd0})
      begin errors++; $display("FAIL underflow got udf=%b dv=%b ovf=%b count=%0d exp udf=1 dv=0 ovf=1 count=0", s_udf, s_dv, s_ovf, s_count); end
  endtask

  // Scenario 3: simultaneous read and write while full is accepted.
  task automatic test_full_rw();
    pulse_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if ({s_count, s_ovf, s_dout} !== {4'd8, 1'b0, 8'h01})
      begin errors++; $display("FAIL full_rw got count=%0d ovf=%b dout=%h exp count=8 ovf=0 dout=01", s_count, s_ovf, s_dout); end
    for (int k = 2; k <= 9; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (s_dout !== ((k == 9) ? 8'h55 : W'(k)))
        begin errors++; $display("FAIL full_rw_drain k=%0d got=%h exp=%h", k, s_dout, (k == 9) ? 8'h55 : W'(k)); end
    end
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty got=%b exp=1", s_empty); end
  endtask

  // Scenario 4: interleaved traffic across several pointer wraps.
  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, W'(i), (i > 0), 1'b0);
      checks++; if (s_count > 4'd2) begin errors++; $display("FAIL wrap_count i=%0d got=%0d exp<=2", i, s_count); end
      if (i > 0) begin
        checks++; if (s_dout !== W'(i - 1)) begin errors++; $display("FAIL wrap_dout i=%0d got=%h exp=%h", i, s_dout, i - 1); end
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({s_dout, s_empty} !== {8'd19, 1'b1})
      begin errors++; $display("FAIL wrap_last got dout=%h empty=%b exp dout=13 empty=1", s_dout, s_empty); end
  endtask

  // Scenario 5: first-word-fall-through presentation and popping.
  task automatic test_fwft();
    pulse_reset();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if ({f_dv, f_dout} !== {1'b1, 8'h3C})
      begin errors++; $display("FAIL fwft_first got dv=%b dout=%h exp dv=1 dout=3c", f_dv, f_dout); end
    drive(1'b1, 8'h4D, 1'b0, 1'b0);
    checks++; if (f_dout !== 8'h3C) begin errors++; $display("FAIL fwft_hold got=%h exp=3c", f_dout); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({f_dv, f_dout} !== {1'b1, 8'h4D})
      begin errors++; $display("FAIL fwft_pop got dv=%b dout=%h exp dv=1 dout=4d", f_dv, f_dout); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({f_dv, f_empty} !== 2'b01)
      begin errors++; $display("FAIL fwft_empty got dv=%b empty=%b exp dv=0 empty=1", f_dv, f_empty); end
  endtask

  // Scenario 6: clear mid-stream discards words and sticky flags.
  task automatic test_clear();
    pulse_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({s_count, s_ovf} !== {4'd5, 1'b1})
      begin errors++; $display("FAIL clear_pre got count=%0d ovf=%b exp count=5 ovf=1", s_count, s_ovf); end
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    checks++; if ({s_count, s_ovf, s_empty, s_dv} !== {4'd0, 1'b0, 1'b1, 1'b0})
      begin errors++; $display("FAIL clear got count=%0d ovf=%b empty=%b dv=%b exp 0 0 1 0", s_count, s_ovf, s_empty, s_dv); end
    drive(1'b1, 8'hE7, 1'b0, 1'b0);
    checks++; if ({f_dv, f_dout, f_count} !== {1'b1, 8'hE7, 4'd1})
      begin errors++; $display("FAIL clear_fwft got dv=%b dout=%h count=%0d exp 1 e7 1", f_dv, f_dout, f_count); end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if ({s_dv, s_dout} !== {1'b1, 8'hE7})
      begin errors++; $display("FAIL clear_read got dv=%b dout=%h exp dv=1 dout=e7", s_dv, s_dout); end
  endtask

  // Randomised traffic with fill-biased and drain-biased phases plus rare clears.
  task automatic test_random();
    logic         w, r, c;
    logic [W-1:0] d;
    logic [6:0]   exp_flags;
    pulse_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((cyc / 100) % 2 == 0) begin
        w = ($urandom_range(3) != 0); r = ($urandom_range(3) == 0);
      end else begin
        w = ($urandom_range(3) == 0); r = ($urandom_range(3) != 0);
      end
      c = ($urandom_range(63) == 0);
      d = W'($urandom);
      drive(w, d, r, c);
      exp_flags = {q.size() == D, q.size() == 0, q.size() >= AF, q.size() <= AE, m_ovf, m_udf, m_dv};
      checks++; if (s_count !== 4'(q.size()))
        begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, s_count, q.size()); end
      checks++; if ({s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_dv} !== exp_flags)
        begin errors++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_dv}, exp_flags); end
      checks++; if (s_dout !== m_dout)
        begin errors++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", cyc, s_dout, m_dout); end
      checks++; if ({f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_dv} !== {4'(q.size()), exp_flags[6:1], q.size() != 0})
        begin errors++; $display("FAIL rand_fwft_status cyc=%0d got count=%0d flags=%b", cyc, f_count, {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_dv}); end
      if (q.size() != 0) begin
        checks++; if (f_dout !== q[0])
          begin errors++; $display("FAIL rand_fwft_dout cyc=%0d got=%h exp=%h", cyc, f_dout, q[0]); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill_overfill();
    test_full_rw();
    test_wrap();
    test_fwft();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fifo_sync_param
